// File: rtl/riscv_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_mem_pkg
//  Description : Shared definitions for the data-memory arbiter: default
//                address/data widths, the arbiter state encoding and a small
//                helper that maps a port index to its ownership state.
//  Contents    : DMEM_ADDR_W, DMEM_DATA_W, arb_state_e, own_state()
//  Revision    : 1.0  initial release
// ============================================================================
package riscv_mem_pkg;

    localparam int unsigned DMEM_ADDR_W = 10;
    localparam int unsigned DMEM_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    // Ownership state for the port that just took a locked access.
    function automatic arb_state_e own_state(input logic port1);
        return port1 ? OWN1 : OWN0;
    endfunction

endpackage : riscv_mem_pkg
`default_nettype wire

// File: rtl/dmem_arb_pick.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arb_pick
//  Description : Combinational two-way request picker. When both requests
//                are present, prio1_i selects the winner (0 = port 0,
//                1 = port 1). A lone request always wins; no request, no grant.
//  Ports       : req0_i, req1_i  - requests
//                prio1_i         - tie-break selector
//                gnt0_o, gnt1_o  - one-hot (or zero) grants
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_arb_pick
    import riscv_mem_pkg::*;
(
    input  logic req0_i,
    input  logic req1_i,
    input  logic prio1_i,
    output logic gnt0_o,
    output logic gnt1_o
);

    assign gnt0_o = req0_i & ~(req1_i &  prio1_i);
    assign gnt1_o = req1_i & ~(req0_i & ~prio1_i);

endmodule : dmem_arb_pick
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Two-port arbiter in front of a single-ported data memory
//                with combinational read. Port 0 is the CPU memory stage,
//                port 1 the loader/debug port. Grants are combinational in
//                the request cycle; load data is captured at the grant edge
//                and presented with a one-cycle rvalid pulse. A locked access
//                keeps ownership with the granting port (atomic RMW) until it
//                issues an unlocked access or drops valid.
//  Config      : DMEM_ARB_RR_EN - when defined, contention in IDLE is
//                resolved round-robin; otherwise port 0 has fixed priority.
//  Ports       : clk, rst (sync, active-high)
//                rq0_* / rq1_* - request ports (valid, write, lock, addr,
//                                wdata in; ready, rvalid, rdata out)
//                mem_*         - data memory strobes, address, data
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = DMEM_ADDR_W,
    parameter int unsigned DATA_W = DMEM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              rq0_valid,
    input  logic              rq0_write,
    input  logic              rq0_lock,
    input  logic [ADDR_W-1:0] rq0_addr,
    input  logic [DATA_W-1:0] rq0_wdata,
    output logic              rq0_ready,
    output logic              rq0_rvalid,
    output logic [DATA_W-1:0] rq0_rdata,

    input  logic              rq1_valid,
    input  logic              rq1_write,
    input  logic              rq1_lock,
    input  logic [ADDR_W-1:0] rq1_addr,
    input  logic [DATA_W-1:0] rq1_wdata,
    output logic              rq1_ready,
    output logic              rq1_rvalid,
    output logic [DATA_W-1:0] rq1_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_memwrite,
    output logic              mem_memread,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_e        state_q;
    arb_state_e        state_d;
    logic              rvalid0_q;
    logic              rvalid0_d;
    logic              rvalid1_q;
    logic              rvalid1_d;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata0_d;
    logic [DATA_W-1:0] rdata1_q;
    logic [DATA_W-1:0] rdata1_d;

    logic              pick0;
    logic              pick1;
    logic              prio1;
    logic              gnt0;
    logic              gnt1;

    // ------------------------------------------------------------------------
    // Tie-break source for the IDLE picker
    // ------------------------------------------------------------------------
`ifdef DMEM_ARB_RR_EN
    // rr_q = 1 means port 1 wins the next tie. It follows every grant,
    // including grants made while a port owns the memory.
    logic rr_q;
    logic rr_d;

    always_comb begin
        rr_d = rr_q;
        if (gnt0) begin
            rr_d = 1'b1;
        end else if (gnt1) begin
            rr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end

    assign prio1 = rr_q;
`else
    assign prio1 = 1'b0;
`endif

    dmem_arb_pick u_pick (
        .req0_i  (rq0_valid),
        .req1_i  (rq1_valid),
        .prio1_i (prio1),
        .gnt0_o  (pick0),
        .gnt1_o  (pick1)
    );

    // ------------------------------------------------------------------------
    // Grant decode. Grants are suppressed while rst is high so nothing
    // reaches memory during reset even though the inputs may be active.
    // ------------------------------------------------------------------------
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    gnt0 = pick0;
                    gnt1 = pick1;
                end
                OWN0:    gnt0 = rq0_valid;
                OWN1:    gnt1 = rq1_valid;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Next state. An owning port keeps the memory only while it keeps
    // issuing locked accesses; an idle cycle or an unlocked access releases.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if ((gnt0 && rq0_lock) || (gnt1 && rq1_lock)) begin
                    state_d = own_state(gnt1);
                end
            end
            OWN0: begin
                if (!gnt0 || !rq0_lock) begin
                    state_d = IDLE;
                end
            end
            OWN1: begin
                if (!gnt1 || !rq1_lock) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Read-data capture happens at the grant edge, only for loads.
    always_comb begin
        rvalid0_d = gnt0 & ~rq0_write;
        rvalid1_d = gnt1 & ~rq1_write;
        rdata0_d  = rvalid0_d ? mem_rdata : rdata0_q;
        rdata1_d  = rvalid1_d ? mem_rdata : rdata1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign rq0_ready  = gnt0;
    assign rq1_ready  = gnt1;
    assign rq0_rvalid = rvalid0_q;
    assign rq1_rvalid = rvalid1_q;
    assign rq0_rdata  = rdata0_q;
    assign rq1_rdata  = rdata1_q;

    // Memory bus is zero when nothing is granted.
    assign mem_addr     = gnt0 ? rq0_addr  : (gnt1 ? rq1_addr  : '0);
    assign mem_wdata    = gnt0 ? rq0_wdata : (gnt1 ? rq1_wdata : '0);
    assign mem_memwrite = (gnt0 & rq0_write)  | (gnt1 & rq1_write);
    assign mem_memread  = (gnt0 & ~rq0_write) | (gnt1 & ~rq1_write);

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Directed self-checking bench for dmem_arbiter. A small
//                memory model returns 0x5A5A0000 | addr, except address
//                0x3FF which returns 0xDEADBEEF.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;

    logic          clk;
    logic          rst;
    logic          rq0_valid, rq0_write, rq0_lock;
    logic [AW-1:0] rq0_addr;
    logic [DW-1:0] rq0_wdata;
    logic          rq0_ready, rq0_rvalid;
    logic [DW-1:0] rq0_rdata;
    logic          rq1_valid, rq1_write, rq1_lock;
    logic [AW-1:0] rq1_addr;
    logic [DW-1:0] rq1_wdata;
    logic          rq1_ready, rq1_rvalid;
    logic [DW-1:0] rq1_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_memwrite, mem_memread;
    logic [DW-1:0] mem_rdata;

    // {ready0, ready1, memread, memwrite, rvalid0, rvalid1}
    logic [5:0]    obs;
    assign obs = {rq0_ready, rq1_ready, mem_memread, mem_memwrite, rq0_rvalid, rq1_rvalid};

    assign mem_rdata = (mem_addr == 10'h3FF) ? 32'hDEADBEEF : (32'h5A5A0000 | {22'd0, mem_addr});

    int total = 0;
    int bad   = 0;
`ifdef DMEM_ARB_RR_EN
    int rr_mode = 1;
`else
    int rr_mode = 0;
`endif

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .rq0_valid    (rq0_valid),
        .rq0_write    (rq0_write),
        .rq0_lock     (rq0_lock),
        .rq0_addr     (rq0_addr),
        .rq0_wdata    (rq0_wdata),
        .rq0_ready    (rq0_ready),
        .rq0_rvalid   (rq0_rvalid),
        .rq0_rdata    (rq0_rdata),
        .rq1_valid    (rq1_valid),
        .rq1_write    (rq1_write),
        .rq1_lock     (rq1_lock),
        .rq1_addr     (rq1_addr),
        .rq1_wdata    (rq1_wdata),
        .rq1_ready    (rq1_ready),
        .rq1_rvalid   (rq1_rvalid),
        .rq1_rdata    (rq1_rdata),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_memwrite (mem_memwrite),
        .mem_memread  (mem_memread),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of stimulus on the falling edge, then let it settle.
    task automatic drive(input logic r,
                         input logic v0, input logic w0, input logic l0,
                         input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic v1, input logic w1, input logic l1,
                         input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        @(negedge clk);
        rst = r;
        rq0_valid = v0; rq0_write = w0; rq0_lock = l0; rq0_addr = a0; rq0_wdata = d0;
        rq1_valid = v1; rq1_write = w1; rq1_lock = l1; rq1_addr = a1; rq1_wdata = d1;
        #2;
    endtask

    task automatic test_reset;
        for (int c = 0; c < 2; c++) begin
            drive(1, 1,0,0, 10'h004, 0, 1,0,0, 10'h008, 0);
            total++;
            if (obs !== 6'b000000) begin bad++; $display("FAIL reset_obs c%0d: got %b want 000000", c, obs); end
            total++;
            if (mem_addr !== 10'h000) begin bad++; $display("FAIL reset_addr c%0d: got %h want 000", c, mem_addr); end
        end
        total++;
        if ({rq0_rdata, rq1_rdata} !== 64'd0) begin bad++; $display("FAIL reset_rdata: got %h want 0", {rq0_rdata, rq1_rdata}); end
        // After release, a lone port-1 load is granted at once (IDLE).
        drive(0, 0,0,0, 10'h000, 0, 1,0,0, 10'h100, 0);
        total++;
        if (obs !== 6'b011000) begin bad++; $display("FAIL reset_release_obs: got %b want 011000", obs); end
        total++;
        if (mem_addr !== 10'h100) begin bad++; $display("FAIL reset_release_addr: got %h want 100", mem_addr); end
    endtask

    task automatic test_contention;
        int prev;
        int win;
        logic [5:0]  exp_obs;
        logic [31:0] exp_rd;
        prev = 1;  // port 1 was granted in the release cycle
        for (int k = 0; k < 4; k++) begin
            drive(0, 1,0,0, 10'h004, 0, 1,0,0, 10'h008, 0);
            win = (rr_mode != 0) ? (k % 2) : 0;
            exp_obs = {win == 0, win == 1, 1'b1, 1'b0, prev == 0, prev == 1};
            total++;
            if (obs !== exp_obs) begin bad++; $display("FAIL contention_obs k%0d: got %b want %b", k, obs, exp_obs); end
            total++;
            if (mem_addr !== ((win == 0) ? 10'h004 : 10'h008)) begin
                bad++; $display("FAIL contention_addr k%0d: got %h want %h", k, mem_addr, (win == 0) ? 10'h004 : 10'h008);
            end
            exp_rd = (k == 0) ? 32'h5A5A0100 : ((prev == 0) ? 32'h5A5A0004 : 32'h5A5A0008);
            total++;
            if (((prev == 0) ? rq0_rdata : rq1_rdata) !== exp_rd) begin
                bad++; $display("FAIL contention_rdata k%0d: got %h want %h", k, (prev == 0) ? rq0_rdata : rq1_rdata, exp_rd);
            end
            prev = win;
        end
        drive(0, 0,0,0, 10'h000, 0, 0,0,0, 10'h000, 0);
        exp_obs = {4'b0000, prev == 0, prev == 1};
        total++;
        if (obs !== exp_obs) begin bad++; $display("FAIL contention_tail_obs: got %b want %b", obs, exp_obs); end
    endtask

    task automatic test_load_latency;
        drive(0, 0,0,0, 10'h000, 0, 1,0,0, 10'h3FF, 0);
        total++;
        if (obs !== 6'b011000) begin bad++; $display("FAIL latency_grant_obs: got %b want 011000", obs); end
        total++;
        if (mem_addr !== 10'h3FF) begin bad++; $display("FAIL latency_addr: got %h want 3ff", mem_addr); end
        drive(0, 0,0,0, 10'h000, 0, 0,0,0, 10'h000, 0);
        total++;
        if (obs !== 6'b000001) begin bad++; $display("FAIL latency_rvalid_obs: got %b want 000001", obs); end
        total++;
        if (rq1_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL latency_rdata: got %h want deadbeef", rq1_rdata); end
        drive(0, 0,0,0, 10'h000, 0, 0,0,0, 10'h000, 0);
        total++;
        if (obs !== 6'b000000) begin bad++; $display("FAIL latency_pulse_obs: got %b want 000000", obs); end
        total++;
        if (rq1_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL latency_hold: got %h want deadbeef", rq1_rdata); end
    endtask

    task automatic test_lock;
        drive(0, 0,0,0, 10'h000, 0, 1,0,1, 10'h010, 0);
        total++;
        if (obs !== 6'b011000) begin bad++; $display("FAIL lock_c1_obs: got %b want 011000", obs); end
        drive(0, 1,0,0, 10'h004, 0, 1,1,0, 10'h010, 32'h12345678);
        total++;
        if (obs !== 6'b010101) begin bad++; $display("FAIL lock_c2_obs: got %b want 010101", obs); end
        total++;
        if (mem_wdata !== 32'h12345678) begin bad++; $display("FAIL lock_c2_wdata: got %h want 12345678", mem_wdata); end
        total++;
        if (rq1_rdata !== 32'h5A5A0010) begin bad++; $display("FAIL lock_c2_rdata: got %h want 5a5a0010", rq1_rdata); end
        drive(0, 1,0,0, 10'h004, 0, 0,0,0, 10'h000, 0);
        total++;
        if (obs !== 6'b101000) begin bad++; $display("FAIL lock_c3_obs: got %b want 101000", obs); end
        total++;
        if (mem_addr !== 10'h004) begin bad++; $display("FAIL lock_c3_addr: got %h want 004", mem_addr); end
        drive(0, 0,0,0, 10'h000, 0, 0,0,0, 10'h000, 0);
        total++;
        if (obs !== 6'b000010) begin bad++; $display("FAIL lock_c4_obs: got %b want 000010", obs); end
        total++;
        if (rq0_rdata !== 32'h5A5A0004) begin bad++; $display("FAIL lock_c4_rdata: got %h want 5a5a0004", rq0_rdata); end
    endtask

    task automatic test_lock_abandon;
        drive(0, 1,0,1, 10'h020, 0, 0,0,0, 10'h000, 0);
        total++;
        if (obs !== 6'b101000) begin bad++; $display("FAIL abandon_c1_obs: got %b want 101000", obs); end
        drive(0, 0,0,0, 10'h000, 0, 1,0,0, 10'h030, 0);
        total++;
        if (obs !== 6'b000010) begin bad++; $display("FAIL abandon_c2_obs: got %b want 000010", obs); end
        drive(0, 0,0,0, 10'h000, 0, 1,0,0, 10'h030, 0);
        total++;
        if (obs !== 6'b011000) begin bad++; $display("FAIL abandon_c3_obs: got %b want 011000", obs); end
        drive(0, 0,0,0, 10'h000, 0, 0,0,0, 10'h000, 0);
        total++;
        if (obs !== 6'b000001) begin bad++; $display("FAIL abandon_c4_obs: got %b want 000001", obs); end
        total++;
        if (rq1_rdata !== 32'h5A5A0030) begin bad++; $display("FAIL abandon_rdata: got %h want 5a5a0030", rq1_rdata); end
    endtask

    task automatic test_reset_mid_lock;
        drive(0, 1,0,1, 10'h040, 0, 0,0,0, 10'h000, 0);
        total++;
        if (obs !== 6'b101000) begin bad++; $display("FAIL rstlock_c1_obs: got %b want 101000", obs); end
        drive(1, 1,0,1, 10'h040, 0, 1,0,0, 10'h050, 0);
        total++;
        if (obs !== 6'b000010) begin bad++; $display("FAIL rstlock_c2_obs: got %b want 000010", obs); end
        drive(0, 0,0,0, 10'h000, 0, 1,0,0, 10'h050, 0);
        total++;
        if (obs !== 6'b011000) begin bad++; $display("FAIL rstlock_c3_obs: got %b want 011000", obs); end
        total++;
        if (rq0_rdata !== 32'h0) begin bad++; $display("FAIL rstlock_rdata0: got %h want 0", rq0_rdata); end
        drive(0, 0,0,0, 10'h000, 0, 0,0,0, 10'h000, 0);
        total++;
        if (obs !== 6'b000001) begin bad++; $display("FAIL rstlock_c4_obs: got %b want 000001", obs); end
        total++;
        if (rq1_rdata !== 32'h5A5A0050) begin bad++; $display("FAIL rstlock_rdata1: got %h want 5a5a0050", rq1_rdata); end
    endtask

    initial begin
        rst = 1'b1;
        rq0_valid = 1'b1; rq0_write = 1'b0; rq0_lock = 1'b0; rq0_addr = 10'h004; rq0_wdata = '0;
        rq1_valid = 1'b1; rq1_write = 1'b0; rq1_lock = 1'b0; rq1_addr = 10'h008; rq1_wdata = '0;
        test_reset;
        test_contention;
        test_load_latency;
        test_lock;
        test_lock_abandon;
        test_reset_mid_lock;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_dmem_arbiter
`default_nettype wire
